// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port (I$/D$) memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  localparam int   NUM_PORTS   = 2;
  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-request round-robin selector: on contention the port that did not win last time goes.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic                 vld,
  output logic                 pick
);

  always_comb begin
    vld  = |req;
    pick = PORT_ICACHE;
    if (&req)                 pick = ~last;
    else if (req[PORT_DCACHE]) pick = PORT_DCACHE;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache line requests onto a single memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  arb_state_e state;
  logic       last_gnt;
  logic       pick_vld;
  logic       pick;

  rr_pick u_rr_pick (
    .req  ({p1_enable_i, p0_enable_i}),
    .last (last_gnt),
    .vld  (pick_vld),
    .pick (pick)
  );

  // Acks are qualified by the grant state so stray memory acks never reach a port.
  assign p0_ack_o = (state == GNT0) && mem_ack_i;
  assign p1_ack_o = (state == GNT1) && mem_ack_i;
  assign p_data_o = mem_data_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last_gnt     <= PORT_DCACHE;
      mem_enable_o <= 1'b0;
      busy_o       <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          state        <= pick ? GNT1 : GNT0;
          last_gnt     <= pick;
          mem_enable_o <= 1'b1;
          busy_o       <= 1'b1;
          mem_write_o  <= pick ? p1_write_i : p0_write_i;
          mem_addr_o   <= pick ? p1_addr_i  : p0_addr_i;
          mem_data_o   <= pick ? p1_data_i  : p0_data_i;
        end
        GNT0, GNT1: if (mem_ack_i) begin
          state        <= TURN;
          mem_enable_o <= 1'b0;
          busy_o       <= 1'b0;
        end
        // One dead cycle lets the completed requester drop enable before re-arbitration.
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a transaction-level round-robin reference model.
module tb_mem_arbiter;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
  logic [ADDR_W-1:0] p0_addr_i = '0;
  logic [DATA_W-1:0] p0_data_i = '0;
  logic              p0_ack_o;
  logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [DATA_W-1:0] p1_data_i = '0;
  logic              p1_ack_o;
  logic [DATA_W-1:0] p_data_o;
  logic              mem_enable_o, mem_write_o, busy_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_served;  // model: port granted most recently

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o),
    .p_data_o(p_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DATA_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_port(input int p, input logic en, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      p0_enable_i = en; p0_write_i = w; p0_addr_i = a; p0_data_i = d;
    end else begin
      p1_enable_i = en; p1_write_i = w; p1_addr_i = a; p1_data_i = d;
    end
  endtask

  // Wait for a grant, check it belongs to port p, hold for lat cycles, ack, check TURN.
  // mode 0: requester holds inputs; 1: requester changes addr/data/write; 2: requester drops enable.
  task automatic serve(input int p, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input int lat,
                       input logic [DATA_W-1:0] rd, input int mode);
    int waited;
    waited = 0;
    while (!mem_enable_o && waited < 8) begin
      @(negedge clk_i);
      waited++;
    end
    n_checks++;
    if (mem_enable_o !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_timeout port%0d: mem_enable_o=%b expected 1", p, mem_enable_o);
      set_port(p, 1'b0, 1'b0, '0, '0);
      return;
    end
    n_checks++;
    if (mem_write_o !== w || mem_addr_o !== a || mem_data_o !== d) begin
      n_fail++;
      $display("FAIL grant_port%0d: write=%b addr=%h got, expected write=%b addr=%h",
               p, mem_write_o, mem_addr_o, w, a);
    end
    for (int i = 0; i < lat; i++) begin
      if (mode == 1) set_port(p, 1'b1, ~w, a ^ 32'h300, ~d);
      if (mode == 2) set_port(p, 1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      n_checks++;
      if (mem_enable_o !== 1'b1 || busy_o !== 1'b1 || mem_write_o !== w ||
          mem_addr_o !== a || mem_data_o !== d) begin
        n_fail++;
        $display("FAIL hold_port%0d: en=%b busy=%b addr=%h expected en=1 busy=1 addr=%h",
                 p, mem_enable_o, busy_o, mem_addr_o, a);
      end
    end
    mem_ack_i = 1'b1;
    mem_data_i = rd;
    #1;
    n_checks++;
    if ({p1_ack_o, p0_ack_o} !== ((p == 1) ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL ack_port%0d: {p1,p0}_ack=%b%b", p, p1_ack_o, p0_ack_o);
    end
    n_checks++;
    if (p_data_o !== rd) begin
      n_fail++;
      $display("FAIL rdata_port%0d: p_data_o=%h expected %h", p, p_data_o, rd);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    set_port(p, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if ({mem_enable_o, busy_o, p1_ack_o, p0_ack_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL turn_port%0d: en=%b busy=%b acks=%b%b expected all 0",
               p, mem_enable_o, busy_o, p1_ack_o, p0_ack_o);
    end
    last_served = p[0];
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    mem_data_i = rnd_line();
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({mem_enable_o, busy_o, mem_write_o, p0_ack_o, p1_ack_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%b busy=%b wr=%b acks=%b%b expected 0",
               mem_enable_o, busy_o, mem_write_o, p1_ack_o, p0_ack_o);
    end
    n_checks++;
    if (mem_addr_o !== '0 || mem_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h expected 0", mem_addr_o);
    end
    n_checks++;
    if (p_data_o !== mem_data_i) begin
      n_fail++;
      $display("FAIL rdata_passthru: p_data_o=%h expected %h", p_data_o, mem_data_i);
    end
    rst_i = 1'b1;
    last_served = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    set_port(1, 1'b1, 1'b0, 32'h0000_0400, '0);
    @(negedge clk_i);
    n_checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h400) begin
      n_fail++;
      $display("FAIL read_latency: en=%b addr=%h expected en=1 addr=400", mem_enable_o, mem_addr_o);
    end
    serve(1, 1'b0, 32'h400, '0, 9, {32{8'hA5}}, 0);
    @(negedge clk_i);
  endtask

  task automatic test_contention(input int rounds);
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    int first;
    for (int r = 0; r < rounds; r++) begin
      a0 = {$urandom} & ~32'h1;
      a1 = {$urandom} | 32'h1;
      d0 = rnd_line();
      d1 = rnd_line();
      set_port(0, 1'b1, 1'b1, a0, d0);
      set_port(1, 1'b1, 1'b0, a1, d1);
      first = last_served ? 0 : 1;
      if (first == 0) begin
        serve(0, 1'b1, a0, d0, $urandom_range(0, 4), rnd_line(), 0);
        serve(1, 1'b0, a1, d1, $urandom_range(0, 4), rnd_line(), 0);
      end else begin
        serve(1, 1'b0, a1, d1, $urandom_range(0, 4), rnd_line(), 0);
        serve(0, 1'b1, a0, d0, $urandom_range(0, 4), rnd_line(), 0);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_addr_hold();
    logic [DATA_W-1:0] d;
    d = rnd_line();
    set_port(0, 1'b1, 1'b1, 32'h100, d);
    serve(0, 1'b1, 32'h100, d, 5, rnd_line(), 1);
    @(negedge clk_i);
  endtask

  task automatic test_spurious();
    mem_ack_i = 1'b1;
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_ack: acks=%b%b expected 00", p1_ack_o, p0_ack_o);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_state: en=%b busy=%b expected 0", mem_enable_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    set_port(1, 1'b1, 1'b0, 32'hBEEF_0040, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: en=%b busy=%b expected 0", mem_enable_o, busy_o);
    end
    set_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    last_served = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #1;
    n_checks++;
    if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: acks=%b%b expected 00", p1_ack_o, p0_ack_o);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    n_checks++;
    if (mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack_state: en=%b expected 0", mem_enable_o);
    end
    test_contention(1);
  endtask

  task automatic test_drop_enable();
    set_port(1, 1'b1, 1'b0, 32'h0000_0800, '0);
    serve(1, 1'b0, 32'h800, '0, 4, rnd_line(), 2);
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (mem_enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL regrant_after_drop: en=%b expected 0", mem_enable_o);
    end
  endtask

  task automatic test_random(input int rounds);
    logic              w[2];
    logic [ADDR_W-1:0] a[2];
    logic [DATA_W-1:0] d[2];
    int order[$];
    int mask, p;
    for (int r = 0; r < rounds; r++) begin
      mask = $urandom_range(1, 3);
      order = {};
      for (int q = 0; q < 2; q++) begin
        w[q] = 1'($urandom);
        a[q] = ({$urandom} & ~32'h1) | q;
        d[q] = rnd_line();
        if (mask[q]) set_port(q, 1'b1, w[q], a[q], d[q]);
      end
      if (mask == 3) begin
        order.push_back(last_served ? 0 : 1);
        order.push_back(last_served ? 1 : 0);
      end else begin
        order.push_back(mask == 2 ? 1 : 0);
      end
      while (order.size() > 0) begin
        p = order.pop_front();
        serve(p, w[p], a[p], d[p], $urandom_range(0, 6), rnd_line(), $urandom_range(0, 2));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention(2);
    test_addr_hold();
    test_spurious();
    test_reset_mid();
    test_drop_enable();
    test_random(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 256, memory line width in bits.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 p0_enable_i  input  1  port-0 (instruction cache) request; held high until p0_ack_o.
REQ-006 p0_write_i  input  1  port-0 request is a write.
REQ-007 p0_addr_i  input  ADDR_W  port-0 address.
REQ-008 p0_data_i  input  DATA_W  port-0 write data.
REQ-009 p0_ack_o  output  1  port-0 completion pulse.
REQ-010 p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o: same as REQ-005..009 for port 1 (data cache).
REQ-011 p_data_o  output  DATA_W  read data, broadcast to both ports.
REQ-012 mem_enable_o  output  1  memory request.
REQ-013 mem_write_o  output  1  memory write qualifier.
REQ-014 mem_addr_o  output  ADDR_W  memory address.
REQ-015 mem_data_o  output  DATA_W  memory write data.
REQ-016 mem_data_i  input  DATA_W  memory read data.
REQ-017 mem_ack_i  input  1  memory completion pulse, one cycle.
REQ-018 busy_o  output  1  transaction in flight.

Function
REQ-019 States: IDLE, GNT0, GNT1, TURN.
REQ-020 IDLE: no enable -> stay; exactly one enable -> GNTn for that port; both -> GNTn for port not equal to last_gnt.
REQ-021 On IDLE->GNTn, the block shall register pn_write_i, pn_addr_i, pn_data_i into mem_write_o, mem_addr_o, mem_data_o and set last_gnt=n.
REQ-022 mem_enable_o and busy_o shall be 1 exactly in GNT0/GNT1, driven from registers; latency from request to mem_enable_o is one cycle.
REQ-023 In GNTn with mem_ack_i=1: pn_ack_o=1 combinationally that cycle, other ack 0, next state TURN.
REQ-024 p_data_o shall equal mem_data_i combinationally at all times.
REQ-025 TURN lasts one cycle with mem_enable_o=0, then IDLE; the requester drops enable in this cycle, so no re-grant of a completed request.
REQ-026 mem_ack_i in IDLE or TURN shall be ignored; no pn_ack_o.
REQ-027 Requester dropping enable during GNTn shall not abort; transaction completes, ack still pulsed.
REQ-028 Registered mem_addr_o/mem_data_o/mem_write_o shall hold stable for the whole GNTn state regardless of requester inputs.
REQ-029 No timeout; GNTn persists until mem_ack_i.
REQ-030 Back-to-back contention shall alternate grants (round-robin, no starvation).

Reset
REQ-031 rst_i low: state=IDLE, last_gnt=1, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, busy_o=0, both acks 0, immediately and asynchronously.
REQ-032 Reset mid-transaction shall drop mem_enable_o at once; a later mem_ack_i is ignored per REQ-026.

Structure
REQ-033 State encoding (2-bit) and port indices belong in a shared package with the cache constants.
REQ-034 One sub-module natural: rr_pick (two-request round-robin selector from requests and last_gnt); remaining logic flat.

Verification
REQ-035 p1 alone, read addr 0x0000_0400, ack after 10 cycles with data 0xA5..A5 -> mem_enable_o at cycle 1, mem_addr_o=0x400, p1_ack_o single pulse, p_data_o=0xA5..A5.
REQ-036 Both request same cycle after reset -> port 0 granted first; then port 1 (after TURN); repeated contention alternates 0,1,0,1.
REQ-037 p0 write addr 0x100, changes p0_addr_i to 0x200 during GNT0 -> mem_addr_o stays 0x100 until ack.
REQ-038 Spurious mem_ack_i in IDLE -> no ack on either port, state unchanged.
REQ-039 rst_i low during GNT1 -> mem_enable_o 0 same cycle; ack arriving after release ignored; next request granted normally.
REQ-040 p1 drops enable mid-GNT1 -> transaction finishes, p1_ack_o pulses, returns IDLE via TURN.
